dpram_be_init: RTL and testbench

//  Parametrised simple dual-port RAM: one write port, one read port, one clock.

---
 rtl/dpram_be_init.sv | 122 ++++++++++++
 tb/tb_dpram_be_init.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/dpram_be_init.sv
// rtl/dpram_be_init.sv - simple dual-port RAM with byte-lane writes, read latency 1/2, RDW policy and init sweep
// After reset the FSM sweeps INIT_VAL into every word; requests are accepted only in RUN.
module dpram_be_init #(
    parameter int              WIDTH    = 16,
    parameter int              DEPTH    = 10,
    parameter int              RD_LAT   = 1,
    parameter int              RDW_MODE = 0,
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               wren,
    input  logic [DEPTH-1:0]   wraddress,
    input  logic [WIDTH-1:0]   data,
    input  logic [WIDTH/8-1:0] byteena,
    input  logic               rden,
    input  logic [DEPTH-1:0]   rdaddress,
    output logic [WIDTH-1:0]   q,
    output logic               q_valid,
    output logic               init_busy
);
    localparam int LANES = WIDTH / 8;
    localparam int WORDS = 2 ** DEPTH;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t             state_q;
    logic [DEPTH-1:0]   ptr_q;
    logic               init_busy_q;
    logic [WIDTH-1:0]   mem [WORDS];

    logic               wr_fire;
    logic               rd_fire;
    logic [WIDTH-1:0]   lane_mask;
    logic [WIDTH-1:0]   old_word;
    logic [WIDTH-1:0]   rd_word_d;

    assign wr_fire = (state_q == ST_RUN) && !reset && wren;
    assign rd_fire = (state_q == ST_RUN) && !reset && rden;

    // Read word is taken before this edge's write lands; RDW_MODE=1 merges the enabled lanes in.
    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_mask[8*i +: 8] = {8{byteena[i]}};
        end
        old_word  = mem[rdaddress];
        rd_word_d = old_word;
        if (RDW_MODE == 1 && wren && (wraddress == rdaddress)) begin
            rd_word_d = (old_word & ~lane_mask) | (data & lane_mask);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_INIT;
            ptr_q       <= '0;
            init_busy_q <= 1'b1;
        end else if (state_q == ST_INIT) begin
            ptr_q <= ptr_q + 1'b1;
            if (ptr_q == {DEPTH{1'b1}}) begin
                state_q     <= ST_RUN;
                init_busy_q <= 1'b0;
            end
        end
    end

    // Storage has no reset; only the sweep clears it.
    always_ff @(posedge clock) begin
        if (!reset && state_q == ST_INIT) begin
            mem[ptr_q] <= INIT_VAL;
        end else if (wr_fire) begin
            for (int i = 0; i < LANES; i++) begin
                if (byteena[i]) begin
                    mem[wraddress][8*i +: 8] <= data[8*i +: 8];
                end
            end
        end
    end

    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_data_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
        end else begin
            s1_valid_q <= rd_fire;
            if (rd_fire) begin
                s1_data_q <= rd_word_d;
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic             s2_valid_q;
            logic [WIDTH-1:0] s2_data_q;

            always_ff @(posedge clock) begin
                if (reset) begin
                    s2_valid_q <= 1'b0;
                    s2_data_q  <= '0;
                end else begin
                    s2_valid_q <= s1_valid_q;
                    if (s1_valid_q) begin
                        s2_data_q <= s1_data_q;
                    end
                end
            end

            assign q       = s2_data_q;
            assign q_valid = s2_valid_q;
        end else begin : g_lat1
            assign q       = s1_data_q;
            assign q_valid = s1_valid_q;
        end
    endgenerate

    assign init_busy = init_busy_q;
endmodule

// File: tb/tb_dpram_be_init.sv
// tb/tb_dpram_be_init.sv - randomized + directed bench for dpram_be_init against a word-array model
module tb_dpram_be_init;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        wren = 1'b0;
    logic        rden = 1'b0;
    logic [3:0]  wraddress = '0;
    logic [3:0]  rdaddress = '0;
    logic [15:0] data = '0;
    logic [1:0]  byteena = '0;

    logic [15:0] q_w [3];
    logic [2:0]  qv_w;
    logic [2:0]  busy_w;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    dpram_be_init #(.WIDTH(16), .DEPTH(4), .RD_LAT(1), .RDW_MODE(0), .INIT_VAL(16'h0000)) u_a (
        .clock(clock), .reset(reset), .wren(wren), .wraddress(wraddress), .data(data),
        .byteena(byteena), .rden(rden), .rdaddress(rdaddress), .q(q_w[0]), .q_valid(qv_w[0]),
        .init_busy(busy_w[0]));
    dpram_be_init #(.WIDTH(16), .DEPTH(4), .RD_LAT(2), .RDW_MODE(1), .INIT_VAL(16'h0000)) u_b (
        .clock(clock), .reset(reset), .wren(wren), .wraddress(wraddress), .data(data),
        .byteena(byteena), .rden(rden), .rdaddress(rdaddress), .q(q_w[1]), .q_valid(qv_w[1]),
        .init_busy(busy_w[1]));
    dpram_be_init #(.WIDTH(16), .DEPTH(4), .RD_LAT(1), .RDW_MODE(1), .INIT_VAL(16'hDEAD)) u_c (
        .clock(clock), .reset(reset), .wren(wren), .wraddress(wraddress), .data(data),
        .byteena(byteena), .rden(rden), .rdaddress(rdaddress), .q(q_w[2]), .q_valid(qv_w[2]),
        .init_busy(busy_w[2]));

    // Reference: per-instance word array, a count of sweep words still to write,
    // and a list of pending read results per instance.
    int          lat_c [3] = '{1, 2, 1};
    int          rdw_c [3] = '{0, 1, 1};
    logic [15:0] iv_c  [3] = '{16'h0000, 16'h0000, 16'hDEAD};
    logic [15:0] mm [3][16];
    int          init_left = 16;
    logic [15:0] pend [3][$];
    int          pend_age [3][$];
    logic        ev [3] = '{1'b0, 1'b0, 1'b0};
    logic [15:0] eq [3] = '{16'h0, 16'h0, 16'h0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        logic        run;
        logic [15:0] mask;
        logic [15:0] rv;
        run  = (init_left == 0);
        mask = {{8{byteena[1]}}, {8{byteena[0]}}};
        for (int d = 0; d < 3; d++) begin
            if (reset) begin
                pend[d].delete();
                pend_age[d].delete();
                ev[d] = 1'b0;
                eq[d] = 16'h0;
            end else begin
                for (int k = 0; k < pend_age[d].size(); k++) pend_age[d][k]++;
                if (run && rden) begin
                    rv = mm[d][rdaddress];
                    if (rdw_c[d] == 1 && wren && wraddress == rdaddress)
                        rv = (rv & ~mask) | (data & mask);
                    pend[d].push_back(rv);
                    pend_age[d].push_back(1);
                end
                if (run && wren) mm[d][wraddress] = (mm[d][wraddress] & ~mask) | (data & mask);
                if (!run) mm[d][16 - init_left] = iv_c[d];
                ev[d] = 1'b0;
                if (pend_age[d].size() > 0 && pend_age[d][0] == lat_c[d]) begin
                    ev[d] = 1'b1;
                    eq[d] = pend[d].pop_front();
                    void'(pend_age[d].pop_front());
                end
            end
        end
        if (reset) init_left = 16;
        else if (!run) init_left--;
    endtask

    task automatic cyc(input logic r, input logic we, input logic [3:0] wa, input logic [15:0] d,
                       input logic [1:0] be, input logic re, input logic [3:0] ra);
        reset = r; wren = we; wraddress = wa; data = d; byteena = be; rden = re; rdaddress = ra;
        @(posedge clock);
        #1;
        model_edge();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("busy%0d", k), busy_w[k], init_left > 0);
            check($sformatf("qv%0d", k), qv_w[k], ev[k]);
            check($sformatf("q%0d", k), q_w[k], eq[k]);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 4'h0, 16'h0, 2'b00, 1'b0, 4'h0);
    endtask

    initial begin
        logic [3:0]  wa;
        logic [3:0]  ra;
        logic [15:0] dv;
        // 1: reset, sweep length, all words cleared
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 4'h0, 16'h0, 2'b00, 1'b0, 4'h0);
        for (int i = 0; i < 16; i++) begin
            idle(1);
            check("sweep_busy", busy_w[0], (i < 15) ? 1'b1 : 1'b0);
        end
        for (int a = 0; a < 16; a++) cyc(1'b0, 1'b0, 4'h0, 16'h0, 2'b00, 1'b1, 4'(a));
        idle(2);
        // 2: byte-lane merge
        cyc(1'b0, 1'b1, 4'd5, 16'hA5C3, 2'b11, 1'b0, 4'h0);
        cyc(1'b0, 1'b1, 4'd5, 16'h11FF, 2'b01, 1'b0, 4'h0);
        cyc(1'b0, 1'b0, 4'h0, 16'h0, 2'b00, 1'b1, 4'd5);
        check("lane_merge", q_w[0], 16'hA5FF);
        idle(2);
        // 3: back-to-back reads
        for (int a = 0; a < 4; a++) cyc(1'b0, 1'b1, 4'(a), 16'(a + 1), 2'b11, 1'b0, 4'h0);
        for (int a = 0; a < 4; a++) cyc(1'b0, 1'b0, 4'h0, 16'h0, 2'b00, 1'b1, 4'(a));
        idle(3);
        // 4: same-address read/write
        cyc(1'b0, 1'b1, 4'd7, 16'h1234, 2'b11, 1'b0, 4'h0);
        cyc(1'b0, 1'b1, 4'd7, 16'hBEEF, 2'b11, 1'b1, 4'd7);
        check("rdw_old", q_w[0], 16'h1234);
        check("rdw_new", q_w[2], 16'hBEEF);
        cyc(1'b0, 1'b1, 4'd7, 16'h1234, 2'b11, 1'b0, 4'h0);
        cyc(1'b0, 1'b1, 4'd7, 16'hBEEF, 2'b10, 1'b1, 4'd7);
        check("rdw_lane", q_w[2], 16'hBE34);
        idle(2);
        // random traffic with frequent address collisions
        for (int i = 0; i < 400; i++) begin
            wa = 4'($urandom_range(0, 15));
            ra = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
            dv = 16'($urandom);
            cyc(1'b0, 1'($urandom_range(0, 1)), wa, dv, 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), ra);
        end
        idle(2);
        // 5: reset mid-sweep restarts it; writes during sweep are ignored
        cyc(1'b1, 1'b0, 4'h0, 16'h0, 2'b00, 1'b0, 4'h0);
        idle(6);
        cyc(1'b1, 1'b0, 4'h0, 16'h0, 2'b00, 1'b0, 4'h0);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, 4'd2, 16'hFFFF, 2'b11, 1'b1, 4'd2);
            check("resweep_busy", busy_w[0], (i < 15) ? 1'b1 : 1'b0);
            check("sweep_no_qv", qv_w[0], 1'b0);
        end
        cyc(1'b0, 1'b0, 4'h0, 16'h0, 2'b00, 1'b1, 4'd2);
        check("addr2_clear", q_w[0], 16'h0000);
        check("addr2_initval", q_w[2], 16'hDEAD);
        cyc(1'b0, 1'b0, 4'h0, 16'h0, 2'b00, 1'b1, 4'($urandom_range(0, 15)));
        check("rand_initval", q_w[2], 16'hDEAD);
        // 6: read in flight when reset asserts is dropped
        cyc(1'b0, 1'b0, 4'h0, 16'h0, 2'b00, 1'b1, 4'd9);
        cyc(1'b1, 1'b0, 4'h0, 16'h0, 2'b00, 1'b0, 4'h0);
        check("drop_lat1", qv_w[2], 1'b0);
        check("drop_lat2", qv_w[1], 1'b0);
        idle(18);
        cyc(1'b0, 1'b0, 4'h0, 16'h0, 2'b00, 1'b1, 4'd9);
        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
